ip_codma_ahb_master: RTL and testbench
======================================

// Module: ip_codma_ahb_master
// PURPOSE
//  Bus-side consumer of the codma FIFOs.
//  - Pops address-phase entries (info_t) and issues single AHB-style transfers (NONSEQ only).
//  - Write: sources hwdata from the data storage FIFO. Read: pushes captured hrdata into it.
//  - Sits directly downstream of the address-phase/data FIFOs, upstream of the system bus.
// PARAMETERS
//  ADDR_W  32  address width; must match info_t.addr
//  DATA_W  64  bus data width; must match data_info_t.data_reg
// PORTS
//  clk_i        in   1       single clock
//  reset_n_i    in   1       asynchronous, active-low reset
//  ap_valid_i   in   1       AP FIFO non-empty
//  ap_info_i    in   38      info_t {read,write,addr[31:0],size[3:0]}
//  ap_pop_o     out  1       pop AP FIFO this cycle
//  wd_valid_i   in   1       data FIFO non-empty (write source)
//  wd_data_i    in   DATA_W  data FIFO head
//  wd_pop_o     out  1       pop data FIFO this cycle
//  rd_space_i   in   1       data FIFO has >=2 free entries
//  rd_push_o    out  1       push rd_data_o into data FIFO
//  rd_data_o    out  DATA_W  captured read data
//  haddr_o      out  ADDR_W  bus address
//  htrans_o     out  2       IDLE=2'b00, NONSEQ=2'b10
//  hwrite_o     out  1       1=write
//  hsize_o      out  3       log2(bytes)
//  hwdata_o     out  DATA_W  write data (data phase)
//  hready_i     in   1       slave ready / phase complete
//  hresp_i      in   1       1=ERROR
//  hrdata_i     in   DATA_W  read data
//  busy_o       out  1       any phase outstanding or AP entry pending
//  err_o        out  1       sticky error
//  err_clr_i    in   1       clears err_o, returns FSM to RUN
// BEHAVIOUR
//  Reset: all outputs 0 (htrans_o=IDLE); pipeline flags and FSM cleared immediately, mid-transfer included.
//  Pipeline: A-stage (addr) and D-stage (data) regs, each with valid flag.
//  A-stage advances into D-stage when hready_i=1; it holds all outputs while hready_i=0.
//  Issue rule: ap_pop_o = state==RUN & ap_valid_i & (!A_valid | hready_i) & legal & res_ok.
//    - res_ok: write needs wd_valid_i; read needs rd_space_i.
//  Issue cycle N:
//    - ap_pop_o=1; for a write, wd_pop_o=1 in the same cycle.
//    - N+1: haddr/hwrite/hsize valid, htrans_o=NONSEQ.
//    - The write word is held in the A-stage, then in hwdata_o through the whole data phase.
//  No issue in cycle N: htrans_o=IDLE at N+1 (other address outputs hold last value).
//  Read completion: D-stage read & hready_i & !hresp_i -> rd_push_o=1 next cycle, rd_data_o=hrdata_i.
//  Latency: ap_pop -> rd_push = 3 cycles at zero wait states; each wait state adds 1.
//  Back-to-back transfers: one per cycle at zero wait states. Address of N+1 overlaps data of N.
//  Size: size 0..3 -> hsize_o=size[2:0]. size>3 is illegal.
//  Illegal entry: size>3, or read==write. It is popped, never issued; err_o=1; FSM -> HALT.
//  FSM states: RUN, ERR1, ERR2, HALT.
//    - RUN -> ERR1: on hresp_i=1 & hready_i=0. In ERR1, htrans_o forced IDLE and the pending A-stage is cancelled (no retry).
//    - ERR1 -> ERR2: on hresp_i=1 & hready_i=1. D-stage is dropped (no rd_push); err_o=1.
//    - ERR2 -> HALT: unconditional.
//    - HALT -> RUN: on err_clr_i. No pops in HALT.
//  err_clr_i in RUN: clears err_o only. err_clr_i in ERR1/ERR2: ignored.
//  busy_o = A_valid | D_valid | (ap_valid_i & state==RUN).
// STRUCTURE
//  ip_codma_fifo_pkg additions: htrans_e (IDLE, NONSEQ), hsize decode helper, bus_state_e.
//  info_t and data_info_t are reused unchanged from the package.
//  Single module; no sub-module (pipeline + 4-state FSM < 300 lines).
// TESTING
//  Single read, addr 0x1000, size 3, zero wait:
//    -> NONSEQ at N+1; rd_push at N+3 with rd_data=hrdata 0xDEADBEEF_CAFEF00D.
//  Four back-to-back writes, addr 0x2000..0x2018, wd_valid high:
//    -> 4 consecutive NONSEQ cycles; hwdata matches pop order.
//  Read with 2 wait states (hready_i=0 x2):
//    -> haddr/htrans held; single rd_push after hready_i rises.
//  Write with wd_valid_i=0:
//    -> no ap_pop; htrans IDLE; issues the cycle after wd_valid_i=1.
//  Two-cycle hresp_i error on a read with a queued write:
//    -> htrans IDLE in ERR1; no rd_push; err_o=1; HALT until err_clr_i.
//  Entry size=4 and entry read=write=1:
//    -> popped, nothing on bus, err_o=1. Also: reset_n_i low mid data phase -> all outputs 0 immediately.

Source files
------------

// File: rtl/ip_codma_fifo_pkg.sv
// Shared types for the codma FIFO slice: FIFO entry layouts, bus encodings
// and small decode helpers used by the bus-side master.
package ip_codma_fifo_pkg;

  // Address-phase FIFO entry.
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
  } info_t;

  // Data storage FIFO entry.
  typedef struct packed {
    logic [63:0] data_reg;
  } data_info_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef enum logic [1:0] {
    BUS_RUN,
    BUS_ERR1,
    BUS_ERR2,
    BUS_HALT
  } bus_state_e;

  // Entry size is log2(bytes); only 0..3 map onto the bus.
  function automatic logic [2:0] hsize_decode(input logic [3:0] size);
    return size[2:0];
  endfunction

  // An entry is issuable only with a supported size and exactly one direction.
  function automatic logic info_legal(input info_t info);
    return (info.size <= 4'd3) && (info.read != info.write);
  endfunction

endpackage

// File: rtl/ip_codma_ahb_master.sv
// Bus-side consumer of the codma FIFOs: pops address-phase entries and issues
// single NONSEQ transfers through a two-stage (address/data) pipeline. Write
// data comes from the data FIFO; read data is pushed back into it.
module ip_codma_ahb_master
  import ip_codma_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ap_valid_i,
  input  logic [37:0]       ap_info_i,
  output logic              ap_pop_o,
  input  logic              wd_valid_i,
  input  logic [DATA_W-1:0] wd_data_i,
  output logic              wd_pop_o,
  input  logic              rd_space_i,
  output logic              rd_push_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [DATA_W-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DATA_W-1:0] hrdata_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  bus_state_e state_q, state_d;

  logic              a_valid_q, a_valid_d;
  logic              a_write_q, a_write_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic [2:0]        a_size_q,  a_size_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;

  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

  logic              rd_push_q, rd_push_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q,     err_d;

  info_t ap_info;
  logic  entry_legal;
  logic  res_ok;
  logic  slot_free;
  logic  in_run;
  logic  issue;
  logic  drop;

  assign ap_info = ap_info_i;

  // Decide whether the FIFO head is issued, dropped as illegal, or waits.
  always_comb begin
    entry_legal = info_legal(ap_info);
    res_ok      = ap_info.write ? wd_valid_i : rd_space_i;
    slot_free   = !a_valid_q || hready_i;
    in_run      = (state_q == BUS_RUN);
    issue       = in_run && ap_valid_i && slot_free && entry_legal && res_ok;
    drop        = in_run && ap_valid_i && !entry_legal;
  end

  // Pop strobes and busy are combinational from live inputs, so they are
  // masked by reset to keep every output low while reset is asserted.
  assign ap_pop_o  = reset_n_i && (issue || drop);
  assign wd_pop_o  = reset_n_i && issue && ap_info.write;
  assign busy_o    = reset_n_i && (a_valid_q || d_valid_q || (ap_valid_i && in_run));

  assign htrans_o  = (a_valid_q && state_q != BUS_ERR1) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o   = a_addr_q;
  assign hwrite_o  = a_write_q;
  assign hsize_o   = a_size_q;
  assign hwdata_o  = d_wdata_q;
  assign rd_push_o = rd_push_q;
  assign rd_data_o = rd_data_q;
  assign err_o     = err_q;

  // Address/data pipeline movement, error cancellation and read capture.
  always_comb begin
    a_valid_d = a_valid_q;
    a_write_d = a_write_q;
    a_addr_d  = a_addr_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;

    if (state_q == BUS_ERR1) begin
      // Pending address phase is abandoned; the errored data phase drops on completion.
      a_valid_d = 1'b0;
      if (hready_i) begin
        d_valid_d = 1'b0;
      end
    end else if (hready_i) begin
      d_valid_d = a_valid_q;
      a_valid_d = 1'b0;
      if (a_valid_q) begin
        d_write_d = a_write_q;
        if (a_write_q) begin
          d_wdata_d = a_wdata_q;
        end
      end
    end

    if (issue) begin
      a_valid_d = 1'b1;
      a_write_d = ap_info.write;
      a_addr_d  = ap_info.addr;
      a_size_d  = hsize_decode(ap_info.size);
      if (ap_info.write) begin
        a_wdata_d = wd_data_i;
      end
    end

    rd_push_d = d_valid_q && !d_write_q && hready_i && !hresp_i && (state_q != BUS_ERR1);
    rd_data_d = rd_push_d ? hrdata_i : rd_data_q;
  end

  // Error handling FSM and sticky error flag.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      BUS_RUN: begin
        if (err_clr_i) begin
          err_d = 1'b0;
        end
        if (drop) begin
          err_d = 1'b1;
        end
        if (hresp_i && !hready_i) begin
          state_d = BUS_ERR1;
        end else if (drop) begin
          state_d = BUS_HALT;
        end
      end
      BUS_ERR1: begin
        if (hresp_i && hready_i) begin
          state_d = BUS_ERR2;
          err_d   = 1'b1;
        end
      end
      BUS_ERR2: begin
        state_d = BUS_HALT;
      end
      BUS_HALT: begin
        if (err_clr_i) begin
          state_d = BUS_RUN;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = BUS_RUN;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= BUS_RUN;
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_addr_q  <= '0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      rd_push_q <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_valid_d;
      a_write_q <= a_write_d;
      a_addr_q  <= a_addr_d;
      a_size_q  <= a_size_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      rd_push_q <= rd_push_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ip_codma_ahb_master.sv
// Directed bench for ip_codma_ahb_master with a transaction-queue bus model
// checked every cycle, plus literal expectations for each scenario.
module tb_ip_codma_ahb_master;
  import ip_codma_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ap_valid_i = 1'b0;
  logic [37:0] ap_info_i = '0;
  logic        ap_pop_o;
  logic        wd_valid_i = 1'b0;
  logic [63:0] wd_data_i = '0;
  logic        wd_pop_o;
  logic        rd_space_i = 1'b1;
  logic        rd_push_o;
  logic [63:0] rd_data_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [63:0] hwdata_o;
  logic        hready_i = 1'b1;
  logic        hresp_i = 1'b0;
  logic [63:0] hrdata_i = '0;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i = 1'b0;

  always #5 clk = ~clk;

  ip_codma_ahb_master #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .ap_valid_i(ap_valid_i), .ap_info_i(ap_info_i), .ap_pop_o(ap_pop_o),
    .wd_valid_i(wd_valid_i), .wd_data_i(wd_data_i), .wd_pop_o(wd_pop_o),
    .rd_space_i(rd_space_i), .rd_push_o(rd_push_o), .rd_data_o(rd_data_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i),
    .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural bus model ----------------
  localparam int M_RUN = 0, M_ERR1 = 1, M_ERR2 = 2, M_HALT = 3;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
  } xfer_t;

  // Outstanding transfers oldest first; the first n_data of them are in the data phase.
  xfer_t       bus_q[$];
  int          n_data = 0;
  int          m_st = M_RUN;
  bit          m_err = 1'b0;
  bit          m_push = 1'b0;
  logic [63:0] m_rdata = '0;
  logic [31:0] m_addr = '0;
  bit          m_write = 1'b0;
  logic [2:0]  m_size = '0;

  function automatic bit head_legal();
    info_t e;
    e = ap_info_i;
    return (e.size <= 4'd3) && (e.read != e.write);
  endfunction

  // Does the AP FIFO head leave the FIFO this cycle?
  function automatic bit m_take();
    info_t e;
    e = ap_info_i;
    if (!rst_n || m_st != M_RUN || !ap_valid_i) return 1'b0;
    if (!head_legal()) return 1'b1;
    if (bus_q.size() > n_data && !hready_i) return 1'b0;
    return e.write ? wd_valid_i : rd_space_i;
  endfunction

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin : compare
    info_t e;
    bit    has_a;
    e = ap_info_i;
    if (!rst_n) begin
      chk("rst_ap_pop", {63'd0, ap_pop_o}, 64'd0);
      chk("rst_wd_pop", {63'd0, wd_pop_o}, 64'd0);
      chk("rst_htrans", {62'd0, htrans_o}, 64'd0);
      chk("rst_haddr", {32'd0, haddr_o}, 64'd0);
      chk("rst_hwdata", hwdata_o, 64'd0);
      chk("rst_rd_push", {63'd0, rd_push_o}, 64'd0);
      chk("rst_rd_data", rd_data_o, 64'd0);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
    end else begin
      has_a = bus_q.size() > n_data;
      chk("m_ap_pop", {63'd0, ap_pop_o}, {63'd0, m_take()});
      chk("m_wd_pop", {63'd0, wd_pop_o}, {63'd0, m_take() && head_legal() && e.write});
      chk("m_htrans", {62'd0, htrans_o}, (has_a && m_st != M_ERR1) ? 64'd2 : 64'd0);
      chk("m_haddr", {32'd0, haddr_o}, {32'd0, m_addr});
      chk("m_hwrite", {63'd0, hwrite_o}, {63'd0, m_write});
      chk("m_hsize", {61'd0, hsize_o}, {61'd0, m_size});
      if (n_data == 1 && bus_q[0].write) chk("m_hwdata", hwdata_o, bus_q[0].data);
      chk("m_rd_push", {63'd0, rd_push_o}, {63'd0, m_push});
      chk("m_rd_data", rd_data_o, m_rdata);
      chk("m_err", {63'd0, err_o}, {63'd0, m_err});
      chk("m_busy", {63'd0, busy_o},
          {63'd0, (bus_q.size() > 0) || (ap_valid_i && m_st == M_RUN)});
    end
  end

  // Advance the model at each clock edge from the inputs of the closing cycle.
  always @(posedge clk) begin : model_upd
    info_t e;
    xfer_t t;
    xfer_t nx;
    bit    take, legal, new_push;
    if (!rst_n) begin
      bus_q.delete();
      n_data = 0; m_st = M_RUN; m_err = 0; m_push = 0;
      m_rdata = '0; m_addr = '0; m_write = 0; m_size = '0;
    end else begin
      e = ap_info_i;
      take = m_take();
      legal = head_legal();
      new_push = 1'b0;
      if (m_st == M_ERR1) begin
        if (bus_q.size() > n_data) bus_q.delete(bus_q.size() - 1);
        if (hready_i && n_data == 1) begin
          bus_q.delete(0);
          n_data = 0;
        end
      end else if (hready_i) begin
        if (n_data == 1) begin
          t = bus_q.pop_front();
          if (!t.write && !hresp_i) begin
            new_push = 1'b1;
            m_rdata = hrdata_i;
          end
        end
        n_data = bus_q.size();
      end
      if (take && legal) begin
        nx.write = e.write; nx.addr = e.addr; nx.size = e.size[2:0]; nx.data = wd_data_i;
        bus_q.push_back(nx);
        m_addr = e.addr; m_write = e.write; m_size = e.size[2:0];
      end
      m_push = new_push;
      case (m_st)
        M_RUN: begin
          if (err_clr_i) m_err = 1'b0;
          if (take && !legal) m_err = 1'b1;
          if (hresp_i && !hready_i) m_st = M_ERR1;
          else if (take && !legal) m_st = M_HALT;
        end
        M_ERR1: if (hresp_i && hready_i) begin m_st = M_ERR2; m_err = 1'b1; end
        M_ERR2: m_st = M_HALT;
        default: if (err_clr_i) begin m_st = M_RUN; m_err = 1'b0; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  info_t       ap_q[$];
  logic [63:0] wd_q[$];
  bit          wd_gate = 1'b1;
  bit          ap_popped, wd_popped;

  function automatic info_t mk(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s);
    info_t r;
    r.read = rd; r.write = wr; r.addr = a; r.size = s;
    return r;
  endfunction

  // Present FIFO heads, then move to mid-cycle where outputs are observed.
  task automatic look();
    ap_valid_i = ap_q.size() > 0;
    ap_info_i = '0;
    if (ap_q.size() > 0) ap_info_i = ap_q[0];
    wd_valid_i = wd_gate && (wd_q.size() > 0);
    wd_data_i = '0;
    if (wd_q.size() > 0) wd_data_i = wd_q[0];
    @(negedge clk);
  endtask

  // Close the cycle: retire popped FIFO entries after the edge.
  task automatic tick();
    ap_popped = ap_pop_o;
    wd_popped = wd_pop_o;
    @(posedge clk);
    #1;
    if (ap_popped && ap_q.size() > 0) ap_q.delete(0);
    if (wd_popped && wd_q.size() > 0) wd_q.delete(0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      look();
      tick();
    end
  endtask

  logic [63:0] wdat[4];

  initial begin
    // Reset state
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_htrans", {62'd0, htrans_o}, 64'd0);
      chk("reset_busy", {63'd0, busy_o}, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Single read, zero wait: NONSEQ at N+1, push at N+3
    ap_q.push_back(mk(1, 0, 32'h1000, 4'd3));
    look(); chk("t1_pop", {63'd0, ap_pop_o}, 64'd1); chk("t1_idle_n", {62'd0, htrans_o}, 64'd0); tick();
    look(); chk("t1_htrans", {62'd0, htrans_o}, 64'd2); chk("t1_haddr", {32'd0, haddr_o}, 64'h1000);
    chk("t1_hsize", {61'd0, hsize_o}, 64'd3); chk("t1_hwrite", {63'd0, hwrite_o}, 64'd0); tick();
    hrdata_i = 64'hDEADBEEF_CAFEF00D;
    look(); chk("t1_nopush_n2", {63'd0, rd_push_o}, 64'd0); tick();
    hrdata_i = '0;
    look(); chk("t1_push", {63'd0, rd_push_o}, 64'd1); chk("t1_rdata", rd_data_o, 64'hDEADBEEF_CAFEF00D); tick();
    look(); chk("t1_single_push", {63'd0, rd_push_o}, 64'd0); tick();
    idle(2);

    // Four back-to-back writes
    for (int k = 0; k < 4; k++) begin
      wdat[k] = 64'hA5A5_0000_0000_0000 + 64'(k * 17 + 3);
      ap_q.push_back(mk(0, 1, 32'h2000 + 32'(k * 8), 4'd3));
      wd_q.push_back(wdat[k]);
    end
    for (int c = 0; c < 6; c++) begin
      look();
      if (c < 4) begin
        chk("t2_ap_pop", {63'd0, ap_pop_o}, 64'd1);
        chk("t2_wd_pop", {63'd0, wd_pop_o}, 64'd1);
      end
      if (c >= 1 && c <= 4) begin
        chk("t2_htrans", {62'd0, htrans_o}, 64'd2);
        chk("t2_haddr", {32'd0, haddr_o}, 64'h2000 + 64'((c - 1) * 8));
        chk("t2_hwrite", {63'd0, hwrite_o}, 64'd1);
      end
      if (c >= 2) chk("t2_hwdata", hwdata_o, wdat[c - 2]);
      if (c == 5) chk("t2_idle_after", {62'd0, htrans_o}, 64'd0);
      tick();
    end
    idle(2);

    // Read with two wait states held in the address phase
    ap_q.push_back(mk(1, 0, 32'h3000, 4'd2));
    look(); chk("t3_pop", {63'd0, ap_pop_o}, 64'd1); tick();
    for (int c = 1; c <= 3; c++) begin
      hready_i = (c == 3);
      look();
      chk("t3_htrans_held", {62'd0, htrans_o}, 64'd2);
      chk("t3_haddr_held", {32'd0, haddr_o}, 64'h3000);
      chk("t3_hsize", {61'd0, hsize_o}, 64'd2);
      chk("t3_nopush", {63'd0, rd_push_o}, 64'd0);
      tick();
    end
    hready_i = 1'b1;
    hrdata_i = 64'h1122_3344_5566_7788;
    look(); chk("t3_nopush_d", {63'd0, rd_push_o}, 64'd0); tick();
    hrdata_i = '0;
    look(); chk("t3_push", {63'd0, rd_push_o}, 64'd1); chk("t3_rdata", rd_data_o, 64'h1122_3344_5566_7788); tick();
    look(); chk("t3_single_push", {63'd0, rd_push_o}, 64'd0); tick();
    idle(2);

    // Write waiting on write data
    wd_gate = 1'b0;
    ap_q.push_back(mk(0, 1, 32'h4000, 4'd1));
    wd_q.push_back(64'h5555_AAAA_0F0F_F0F0);
    look(); chk("t4_no_pop", {63'd0, ap_pop_o}, 64'd0); chk("t4_no_wdpop", {63'd0, wd_pop_o}, 64'd0);
    chk("t4_busy", {63'd0, busy_o}, 64'd1); tick();
    look(); chk("t4_idle", {62'd0, htrans_o}, 64'd0); chk("t4_no_pop2", {63'd0, ap_pop_o}, 64'd0); tick();
    wd_gate = 1'b1;
    look(); chk("t4_pop", {63'd0, ap_pop_o}, 64'd1); chk("t4_wdpop", {63'd0, wd_pop_o}, 64'd1); tick();
    look(); chk("t4_htrans", {62'd0, htrans_o}, 64'd2); chk("t4_haddr", {32'd0, haddr_o}, 64'h4000);
    chk("t4_hsize", {61'd0, hsize_o}, 64'd1); chk("t4_hwrite", {63'd0, hwrite_o}, 64'd1); tick();
    look(); chk("t4_hwdata", hwdata_o, 64'h5555_AAAA_0F0F_F0F0); tick();
    idle(2);

    // Two-cycle error response on a read with a queued write
    ap_q.push_back(mk(1, 0, 32'h5000, 4'd3));
    ap_q.push_back(mk(0, 1, 32'h5008, 4'd3));
    wd_q.push_back(64'h0BAD_0BAD_0BAD_0BAD);
    look(); chk("t5_pop_rd", {63'd0, ap_pop_o}, 64'd1); tick();
    look(); chk("t5_pop_wr", {63'd0, wd_pop_o}, 64'd1); chk("t5_haddr_rd", {32'd0, haddr_o}, 64'h5000); tick();
    hready_i = 1'b0; hresp_i = 1'b1;
    look(); chk("t5_htrans_wr", {62'd0, htrans_o}, 64'd2); chk("t5_haddr_wr", {32'd0, haddr_o}, 64'h5008); tick();
    hready_i = 1'b1; hresp_i = 1'b1;
    look(); chk("t5_err1_idle", {62'd0, htrans_o}, 64'd0); chk("t5_err_not_yet", {63'd0, err_o}, 64'd0); tick();
    hresp_i = 1'b0;
    look(); chk("t5_no_push", {63'd0, rd_push_o}, 64'd0); chk("t5_err", {63'd0, err_o}, 64'd1);
    chk("t5_idle_err2", {62'd0, htrans_o}, 64'd0); tick();
    ap_q.push_back(mk(1, 0, 32'h6000, 4'd3));
    look(); chk("t5_halt_nopop", {63'd0, ap_pop_o}, 64'd0); chk("t5_halt_busy", {63'd0, busy_o}, 64'd0);
    chk("t5_halt_err", {63'd0, err_o}, 64'd1); tick();
    err_clr_i = 1'b1;
    look(); chk("t5_clr_nopop", {63'd0, ap_pop_o}, 64'd0); tick();
    err_clr_i = 1'b0;
    look(); chk("t5_run_err", {63'd0, err_o}, 64'd0); chk("t5_run_pop", {63'd0, ap_pop_o}, 64'd1); tick();
    look(); chk("t5_resume", {32'd0, haddr_o}, 64'h6000); tick();
    hrdata_i = 64'h0000_6000_0000_6000;
    idle(1);
    hrdata_i = '0;
    idle(2);

    // Illegal entries: size 4, then read==write
    ap_q.push_back(mk(1, 0, 32'h7000, 4'd4));
    look(); chk("t6_pop_sz", {63'd0, ap_pop_o}, 64'd1); chk("t6_nowd_sz", {63'd0, wd_pop_o}, 64'd0); tick();
    look(); chk("t6_idle_sz", {62'd0, htrans_o}, 64'd0); chk("t6_err_sz", {63'd0, err_o}, 64'd1); tick();
    err_clr_i = 1'b1; idle(1); err_clr_i = 1'b0;
    look(); chk("t6_cleared", {63'd0, err_o}, 64'd0); tick();
    ap_q.push_back(mk(1, 1, 32'h7100, 4'd0));
    look(); chk("t6_pop_rw", {63'd0, ap_pop_o}, 64'd1); chk("t6_nowd_rw", {63'd0, wd_pop_o}, 64'd0); tick();
    look(); chk("t6_idle_rw", {62'd0, htrans_o}, 64'd0); chk("t6_err_rw", {63'd0, err_o}, 64'd1); tick();
    err_clr_i = 1'b1; idle(1); err_clr_i = 1'b0;
    idle(2);

    // Reset asserted mid data phase
    ap_q.push_back(mk(1, 0, 32'h8000, 4'd3));
    ap_q.push_back(mk(1, 0, 32'h8008, 4'd3));
    ap_q.push_back(mk(1, 0, 32'h8010, 4'd3));
    idle(2);
    hready_i = 1'b0;
    look(); chk("t7_active", {62'd0, htrans_o}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_htrans", {62'd0, htrans_o}, 64'd0);
    chk("t7_haddr", {32'd0, haddr_o}, 64'd0);
    chk("t7_hsize", {61'd0, hsize_o}, 64'd0);
    chk("t7_ap_pop", {63'd0, ap_pop_o}, 64'd0);
    chk("t7_busy", {63'd0, busy_o}, 64'd0);
    chk("t7_rd_data", rd_data_o, 64'd0);
    chk("t7_err", {63'd0, err_o}, 64'd0);
    ap_q.delete();
    wd_q.delete();
    hready_i = 1'b1;
    tick();
    idle(2);
    rst_n = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
